follower_lanes: RTL
===================

Name: follower_lanes

Overview:
- Receiving end of the vertical-scroll interface. Consumes the one-cycle move_followers pulse and moves NUM_LANES car-obstacle rows down the screen in lockstep with the background scroll.
- Each row also drifts horizontally at its own direction and wraps at the screen edges.
- Rows that fall off the bottom re-enter at the top with an LFSR-chosen x and direction.
- Detects player/obstacle overlap and latches a crash state that freezes all obstacles until reset.

Parameters:
- NUM_LANES, 4, number of obstacle rows (index i = 0..NUM_LANES-1).
- MOVE_AMT, 2, vertical pixels per move_followers pulse.
- SCREEN_HEIGHT, 480, vertical wrap bound.
- SCREEN_WIDTH, 640, horizontal wrap bound.
- LANE_SPACING, 120, reset y spacing between rows.
- H_SPEED, 100000, clk cycles per horizontal step.
- H_STEP, 1, horizontal pixels per step.
- OBST_W, 32, obstacle width in pixels.
- OBST_H, 16, obstacle height in pixels.
- PLAYER_W, 16, player width in pixels.
- PLAYER_H, 16, player height in pixels.

Ports:
- clk  input  1  system clock (25 MHz pixel clock).
- reset  input  1  synchronous, active-high.
- move_followers  input  1  one-cycle scroll pulse from the vertical scroll block.
- player_x  input  10  player left edge.
- player_y  input  10  player top edge.
- obst_x  output  10*NUM_LANES  packed row x positions; row i at [10i+9:10i].
- obst_y  output  10*NUM_LANES  packed row y positions; same packing.
- obst_dir  output  NUM_LANES  per-row direction: 0 = right, 1 = left.
- wrap_pulse  output  1  one-cycle pulse on any vertical wrap.
- crashed  output  1  high while in CRASH.

Behaviour:
- Reset, all outputs registered:
  - row i: y = i*LANE_SPACING, x = (i*160) mod SCREEN_WIDTH, dir = i[0].
  - wrap_pulse = 0, crashed = 0, state = RUN, h_ctr = 0.
  - LFSR = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle except during reset, including in CRASH.
- FSM states: RUN and CRASH.
  - RUN -> CRASH at any edge where overlap is true.
  - CRASH -> RUN only via reset.
- Overlap: true if any row i satisfies all of the following (unsigned, 11-bit compares, no wrap handling):
  - player_x < x_i + OBST_W
  - x_i < player_x + PLAYER_W
  - player_y < y_i + OBST_H
  - y_i < player_y + PLAYER_H
  Evaluated combinationally on the current registered positions.
- At the edge that enters CRASH, all position, dir and h_ctr updates are suppressed. crashed rises 1 cycle after the overlap cycle.
- In CRASH:
  - move_followers is ignored.
  - h_ctr holds.
  - x, y and dir hold.
  - wrap_pulse = 0.
- Horizontal motion, RUN only:
  - h_ctr counts 0..H_SPEED-1; its width is clog2(H_SPEED).
  - At h_ctr == H_SPEED-1: h_ctr -> 0 and every row steps.
  - Right step: x + H_STEP, minus SCREEN_WIDTH if the result is >= SCREEN_WIDTH.
  - Left step: x - H_STEP if x >= H_STEP, else x + SCREEN_WIDTH - H_STEP.
- Vertical motion, RUN, move_followers = 1:
  - Every row: if y + MOVE_AMT >= SCREEN_HEIGHT, then y -> y + MOVE_AMT - SCREEN_HEIGHT (wrap); else y -> y + MOVE_AMT.
  - A wrapping row takes x = L[9:0] if L[9:0] < SCREEN_WIDTH, else L[9:0] - SCREEN_WIDTH, where L is the current LFSR value. It takes dir = L[10].
  - All rows wrapping in the same cycle take the same x and dir.
  - wrap_pulse = 1 for exactly the cycle after the wrap edge; otherwise 0.
- Simultaneous events:
  - A horizontal step and a vertical pulse in the same cycle both apply.
  - For a wrapping row, the wrap-assigned x and dir override that cycle's horizontal step.
  - Overlap in the same cycle suppresses both.
- Back-to-back move_followers pulses on consecutive cycles each move MOVE_AMT.
- move_followers held high moves every cycle; this is not an error.
- Reset mid-operation: reset wins over all events, including an edge that would enter CRASH.

Test Plan (bench parameters H_SPEED=4, player parked at (600,460) unless stated):
- Reset values: assert reset 2 cycles -> obst_y = {360,240,120,0} (rows 3..0), obst_x = {480,320,160,0}, obst_dir = 4'b1010, crashed = 0, wrap_pulse = 0.
- Horizontal timing: run 8 cycles, no pulses -> exactly 2 steps. Row0 x = 2 (right). Row1 x = 158 (left). No y change.
- Vertical wrap: force row3 y = 478 via reset-free sequence (pulses) and send a pulse.
  - Row3 y -> 0.
  - Row3 x = LFSR-derived value < 640, dir = LFSR[10].
  - wrap_pulse high exactly 1 cycle.
  - Other rows +2.
- Left-edge wrap: row1 at x=0, dir=1, at a step -> x = 639. Right-edge wrap: row at x=639, dir=0 -> x = 0.
- Crash: place player at (row0 x+10, row0 y+4).
  - crashed = 1 next cycle.
  - Further move_followers pulses and 20 cycles leave all obst_x/obst_y unchanged.
  - Reset returns the reset values.
- Simultaneity: a pulse coincides with a horizontal step -> non-wrapping rows change both x (±1) and y (+2) in the same cycle. A pulse coinciding with an overlap edge -> no position change and crashed = 1.

Source files
------------

// File: rtl/follower_lanes.sv
// Obstacle rows that scroll down with the background, drift sideways and wrap,
// re-entering at the top with an LFSR-chosen x/dir; latches a crash on player overlap.
module follower_lanes #(
  parameter int NUM_LANES     = 4,
  parameter int MOVE_AMT      = 2,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SCREEN_WIDTH  = 640,
  parameter int LANE_SPACING  = 120,
  parameter int H_SPEED       = 100000,
  parameter int H_STEP        = 1,
  parameter int OBST_W        = 32,
  parameter int OBST_H        = 16,
  parameter int PLAYER_W      = 16,
  parameter int PLAYER_H      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      move_followers,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  output logic [10*NUM_LANES-1:0]   obst_x,
  output logic [10*NUM_LANES-1:0]   obst_y,
  output logic [NUM_LANES-1:0]      obst_dir,
  output logic                      wrap_pulse,
  output logic                      crashed
);

  localparam int HW = (H_SPEED > 1) ? $clog2(H_SPEED) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_SPEED - 1);

  typedef enum logic {RUN, CRASH} state_t;

  state_t               state_reg, state_next;
  logic [HW-1:0]        h_ctr_reg;
  logic [15:0]          lfsr_reg;
  logic                 wrap_pulse_reg;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] wrap;
  logic                 overlap;
  logic                 advance;
  logic                 h_tick;
  logic [9:0]           wrap_x;
  logic [10:0]          px_ext, py_ext;

  assign px_ext  = {1'b0, player_x};
  assign py_ext  = {1'b0, player_y};
  assign overlap = |hit;
  // Any update is suppressed on the edge that enters CRASH as well as while in it.
  assign advance = (state_reg == RUN) && !overlap;
  assign h_tick  = (h_ctr_reg == H_LAST);
  assign wrap_x  = (lfsr_reg[9:0] < 10'(SCREEN_WIDTH)) ? lfsr_reg[9:0]
                                                      : lfsr_reg[9:0] - 10'(SCREEN_WIDTH);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (overlap) state_next = CRASH;
      CRASH:   state_next = CRASH;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RUN;
      h_ctr_reg      <= '0;
      lfsr_reg       <= 16'hACE1;
      wrap_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lfsr_reg       <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      wrap_pulse_reg <= advance && (|wrap);
      if (advance)
        h_ctr_reg <= h_tick ? '0 : h_ctr_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [9:0]  x_reg, y_reg;
      logic        dir_reg;
      logic [10:0] x_ext, y_ext, y_sum, x_sum;
      logic [9:0]  x_right, x_left;

      assign x_ext = {1'b0, x_reg};
      assign y_ext = {1'b0, y_reg};
      assign y_sum = y_ext + 11'(MOVE_AMT);
      assign x_sum = x_ext + 11'(H_STEP);

      assign hit[gi] = (px_ext < x_ext + 11'(OBST_W)) && (x_ext < px_ext + 11'(PLAYER_W)) &&
                       (py_ext < y_ext + 11'(OBST_H)) && (y_ext < py_ext + 11'(PLAYER_H));
      assign wrap[gi] = move_followers && (y_sum >= 11'(SCREEN_HEIGHT));

      assign x_right = (x_sum >= 11'(SCREEN_WIDTH)) ? 10'(x_sum - 11'(SCREEN_WIDTH)) : x_sum[9:0];
      assign x_left  = (x_reg >= 10'(H_STEP)) ? x_reg - 10'(H_STEP)
                                              : 10'(x_ext + 11'(SCREEN_WIDTH) - 11'(H_STEP));

      always_ff @(posedge clk) begin
        if (reset) begin
          x_reg   <= 10'((gi * 160) % SCREEN_WIDTH);
          y_reg   <= 10'(gi * LANE_SPACING);
          dir_reg <= 1'((gi % 2));
        end else if (advance) begin
          // A re-entering row takes the LFSR position, overriding this cycle's drift.
          if (wrap[gi]) begin
            y_reg   <= 10'(y_sum - 11'(SCREEN_HEIGHT));
            x_reg   <= wrap_x;
            dir_reg <= lfsr_reg[10];
          end else begin
            if (move_followers) y_reg <= y_sum[9:0];
            if (h_tick)         x_reg <= dir_reg ? x_left : x_right;
          end
        end
      end

      assign obst_x[10*gi +: 10] = x_reg;
      assign obst_y[10*gi +: 10] = y_reg;
      assign obst_dir[gi]        = dir_reg;
    end
  endgenerate

  assign wrap_pulse = wrap_pulse_reg;
  assign crashed    = (state_reg == CRASH);

endmodule
